systolic_stream_host: RTL and testbench
=======================================

# systolic_stream_host

AXI-Stream host-side endpoint for the 3x3 systolic-array AXI wrapper. It replaces the DMA end of the link. It packs two locally written 3x3 8-bit operand matrices into three 48-bit stream beats and drives them into the array's slave port. It then accepts the single 144-bit result beat from the array's master port and exposes the nine 16-bit products through a random-read port.

## Interface
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in WAIT, in cycles. Used only when `SYSTOLIC_HOST_TIMEOUT_EN` is defined.
- `axi_clk` in 1: single clock; all logic on rising edge.
- `axi_rst` in 1: reset, asynchronous and active-high.
- `op_wr_en` in 1: operand write strobe.
- `op_wr_addr` in 5: operand address. 0-8 selects A[r][c] at index r*3+c. 9-17 selects B[r][c] at index 9+r*3+c. Addresses 18-31 are ignored.
- `op_wr_data` in 8: operand value, unsigned.
- `start` in 1: begin a transaction; sampled only in IDLE.
- `busy` out 1: high in SEND and WAIT.
- `done` out 1: one-cycle pulse when a transaction ends.
- `err` out 1: registered with `done`; high when the transaction ended by timeout.
- `res_rd_addr` in 4: result index 0-8, C[r][c] at index r*3+c.
- `res_rd_data` out 16: combinational read of the result buffer. Returns 0 for addresses 9-15.
- `m_axis_valid` out 1: operand beat valid (to the array's slave port).
- `m_axis_data` out 48: operand beat.
- `m_axis_ready` in 1: array ready for an operand beat.
- `s_axis_valid` in 1: result beat valid (from the array's master port).
- `s_axis_data` in 144: result beat. C[i] is in bits [i*16+:16].
- `s_axis_ready` out 1: host ready for the result beat.

## Operation
- Operand RAM: 18 x 8-bit registers. A write is accepted when `op_wr_en` is high and the state is IDLE or DONE. Writes in SEND or WAIT are dropped so that beats stay stable.
- Beat k (k = 0, 1, 2) packing:
  - [7:0] = B[0][k], [15:8] = B[1][k], [23:16] = B[2][k]
  - [31:24] = A[k][0], [39:32] = A[k][1], [47:40] = A[k][2]
- State machine:
  - IDLE: `start` high → SEND with beat counter at 0.
  - SEND: `m_axis_valid` = 1 and `m_axis_data` = beat[counter]. The counter increments on `m_axis_valid && m_axis_ready`. The handshake on beat 2 → WAIT.
  - WAIT: `s_axis_ready` = 1. On `s_axis_valid && s_axis_ready`, capture all 144 bits into the result buffer → DONE.
  - DONE: `done` = 1 for exactly one cycle → IDLE.
- `start` is ignored in SEND, WAIT and DONE; it is not queued.
- The result buffer holds its value until the next capture. A timed-out transaction leaves it unchanged.
- Reset values:
  - state IDLE, beat counter 0
  - `m_axis_valid` 0, `m_axis_data` 0, `s_axis_ready` 0
  - `busy` 0, `done` 0, `err` 0
  - operand RAM and result buffer all zero
- Reset mid-transaction aborts immediately. No `done` is generated and no partial result is captured.

## Timing
- `start` is sampled at edge T0. `m_axis_valid` and beat 0 appear after T0, and `busy` rises at the same time.
- With `m_axis_ready` held high, beats 0, 1 and 2 transfer at edges T1, T2 and T3. `s_axis_ready` is high from T3 onward.
- If `s_axis_valid` is already high, capture happens at T4. `done` and the new `res_rd_data` are visible after T4, and `busy` falls at the same time.
- Backpressure: while `m_axis_ready` is low, `m_axis_valid` and `m_axis_data` hold unchanged. Valid never drops before the handshake.
- No combinational path from `m_axis_ready` to `m_axis_valid`, or from `s_axis_valid` to `s_axis_ready`.

## Configuration
- `SYSTOLIC_HOST_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYCLES` without a result handshake, the block goes to DONE with `err` = 1.
  - A handshake on the same cycle as the count reaching the limit wins: capture happens and `err` = 0.
- Not defined: no counter logic. WAIT persists until the handshake, and `err` is tied to 0.

## Test plan
- Beat packing: load A = B = [[1,2,3],[4,5,6],[7,8,9]] and pulse `start` with `m_axis_ready` = 1. Required beats, in order:
  - 48'h030201070401
  - 48'h060504080502
  - 48'h090807090603
  - then exactly three handshakes and `s_axis_ready` rising.
- Result capture: responder returns C = {150,126,102,96,81,66,42,36,30} (index 8 down to 0). Required: one `done` pulse with `err` = 0; `res_rd_addr` 0 reads 30, 4 reads 81, 8 reads 150.
- Backpressure: B = [[10,11,12],[13,14,15],[16,17,18]], with `m_axis_ready` low for 2 cycles while beat 1 is presented. Required: 48'h060504110e0b held stable, no duplicate or dropped beat, beat 2 = 48'h090807120f0c.
- Busy protection: `start` pulse and operand write to address 0 during SEND. Required: both ignored; the next transaction still sends the old A[0][0].
- Reset mid-WAIT: assert `axi_rst` for 1 cycle. Required: all outputs 0, no `done`, and the result buffer reads 0.
- Timeout (macro defined, `TIMEOUT_CYCLES` = 16): `s_axis_valid` is never asserted. Required: `done` with `err` = 1, and the previous result is preserved.

Source files
------------

// File: rtl/systolic_stream_host.sv
// Host-side AXI-Stream endpoint for the 3x3 systolic array: packs operands into three beats, captures the 144-bit result.
// Optional WAIT watchdog is compiled in with `define SYSTOLIC_HOST_TIMEOUT_EN.
module systolic_stream_host #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         axi_clk,
  input  logic         axi_rst,
  input  logic         op_wr_en,
  input  logic [4:0]   op_wr_addr,
  input  logic [7:0]   op_wr_data,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic [3:0]   res_rd_addr,
  output logic [15:0]  res_rd_data,
  output logic         m_axis_valid,
  output logic [47:0]  m_axis_data,
  input  logic         m_axis_ready,
  input  logic         s_axis_valid,
  input  logic [143:0] s_axis_data,
  output logic         s_axis_ready
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t            state_q;
  logic [1:0]        beat_q;
  logic [17:0][7:0]  ram_q;
  logic [8:0][15:0]  res_q;
  logic              m_valid_q, s_ready_q, busy_q, done_q;
  logic [47:0]       m_data_q;
  logic              wr_ok;

`ifdef SYSTOLIC_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Beat k carries column k of B in the low bytes and row k of A in the high bytes.
  function automatic logic [47:0] pack_beat(input logic [17:0][7:0] ram, input logic [1:0] k);
    logic [47:0] b;
    b = '0;
    for (int r = 0; r < 3; r++) begin
      b[r*8 +: 8]      = ram[9 + r*3 + 32'(k)];
      b[24 + r*8 +: 8] = ram[32'(k)*3 + r];
    end
    return b;
  endfunction

  assign wr_ok = op_wr_en && (op_wr_addr < 5'd18) &&
                 ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      ram_q     <= '0;
      res_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      if (wr_ok) ram_q[op_wr_addr] <= op_wr_data;
      case (state_q)
        S_IDLE: if (start) begin
          state_q   <= S_SEND;
          beat_q    <= 2'd0;
          m_valid_q <= 1'b1;
          m_data_q  <= pack_beat(ram_q, 2'd0);
          busy_q    <= 1'b1;
        end
        S_SEND: if (m_valid_q && m_axis_ready) begin
          if (beat_q == 2'd2) begin
            state_q   <= S_WAIT;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
            wd_q      <= '0;
`endif
          end else begin
            beat_q   <= beat_q + 2'd1;
            m_data_q <= pack_beat(ram_q, beat_q + 2'd1);
          end
        end
        S_WAIT: begin
          // A result handshake takes priority over an expiring watchdog.
          if (s_axis_valid && s_ready_q) begin
            res_q     <= s_axis_data;
            state_q   <= S_DONE;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
          else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= S_DONE;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign m_axis_valid = m_valid_q;
  assign m_axis_data  = m_data_q;
  assign s_axis_ready = s_ready_q;
  assign res_rd_data  = (res_rd_addr < 4'd9) ? res_q[res_rd_addr] : 16'h0;

endmodule

// File: tb/tb_systolic_stream_host.sv
// Self-checking bench for systolic_stream_host: table of operand/result vectors plus reset and timeout sequences.
module tb_systolic_stream_host;
  logic         axi_clk = 1'b0;
  logic         axi_rst = 1'b1;
  logic         op_wr_en = 1'b0;
  logic [4:0]   op_wr_addr = '0;
  logic [7:0]   op_wr_data = '0;
  logic         start = 1'b0;
  logic         busy, done, err;
  logic [3:0]   res_rd_addr = '0;
  logic [15:0]  res_rd_data;
  logic         m_axis_valid;
  logic [47:0]  m_axis_data;
  logic         m_axis_ready = 1'b1;
  logic         s_axis_valid = 1'b0;
  logic [143:0] s_axis_data = '0;
  logic         s_axis_ready;

  systolic_stream_host #(
`ifdef SYSTOLIC_HOST_TIMEOUT_EN
    .TIMEOUT_CYCLES(16)
`else
    .TIMEOUT_CYCLES(1024)
`endif
  ) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .op_wr_en(op_wr_en), .op_wr_addr(op_wr_addr), .op_wr_data(op_wr_data),
    .start(start), .busy(busy), .done(done), .err(err),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_ready(m_axis_ready),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_ready(s_axis_ready)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [8:0][7:0]  a;
    logic [8:0][7:0]  b;
    logic [2:0][47:0] beats;
    logic [8:0][15:0] c;
    bit               stall;
    bit               poke;
  } tv_t;

  tv_t         tvs[3];
  int          checks = 0;
  int          errors = 0;
  logic [47:0] exp_q[$];
  int          hs_cnt = 0;
  bit          stalled = 0;
  logic [47:0] stall_data = '0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  // Beat scoreboard and backpressure stability monitor, sampled mid-cycle.
  always @(negedge axi_clk) begin
    if (axi_rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("bp_valid_held", m_axis_valid, 1'b1);
        chk("bp_data_held", m_axis_data, stall_data);
      end
      if (m_axis_valid && m_axis_ready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %0h expected none", m_axis_data);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          if (m_axis_data !== e) begin
            errors++;
            $display("FAIL beat%0d: got %0h expected %0h", hs_cnt - 1, m_axis_data, e);
          end
        end
        stalled = 0;
      end else if (m_axis_valid) begin
        stalled = 1;
        stall_data = m_axis_data;
      end else begin
        stalled = 0;
      end
    end
  end

  task automatic op_write(input int addr, input logic [7:0] data);
    op_wr_en   = 1'b1;
    op_wr_addr = 5'(addr);
    op_wr_data = data;
    tick();
    op_wr_en   = 1'b0;
  endtask

  task automatic check_results(input string name, input logic [8:0][15:0] c);
    logic [15:0] e;
    for (int i = 0; i < 16; i++) begin
      res_rd_addr = 4'(i);
      #1;
      e = (i < 9) ? c[i] : 16'h0;
      chk($sformatf("%s_rd%0d", name, i), res_rd_data, e);
    end
  endtask

  task automatic run_txn(input int idx, input bit load, input bit respond,
                         input bit exp_err, input logic [8:0][15:0] exp_c);
    tv_t tv;
    int  lat, stall_left, exp_lat;
    bit  got_done, saw_sready;
    tv = tvs[idx];
    if (load) begin
      for (int i = 0; i < 9; i++) begin
        op_write(i, tv.a[i]);
        op_write(9 + i, tv.b[i]);
      end
    end
    for (int k = 0; k < 3; k++) exp_q.push_back(tv.beats[k]);
    hs_cnt       = 0;
    s_axis_valid = respond;
    s_axis_data  = tv.c;
    m_axis_ready = 1'b1;
    stall_left   = tv.stall ? 2 : 0;
    got_done     = 0;
    saw_sready   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    chk($sformatf("t%0d_busy_rise", idx), busy, 1'b1);
    for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
      op_wr_en = 1'b0;
      start    = 1'b0;
      if (tv.poke && lat == 1) begin
        op_wr_en = 1'b1; op_wr_addr = 5'd0; op_wr_data = 8'h55;
        start = 1'b1;
        m_axis_ready = 1'b0;
      end else if (hs_cnt == 1 && stall_left > 0) begin
        m_axis_ready = 1'b0;
        stall_left--;
      end else begin
        m_axis_ready = 1'b1;
      end
      tick();
      lat++;
      if (s_axis_ready) saw_sready = 1;
      if (done) got_done = 1;
    end
    op_wr_en = 1'b0;
    start = 1'b0;
    m_axis_ready = 1'b1;
    chk($sformatf("t%0d_done_seen", idx), got_done, 1'b1);
    chk($sformatf("t%0d_err", idx), err, exp_err);
    chk($sformatf("t%0d_busy_fall", idx), busy, 1'b0);
    chk($sformatf("t%0d_handshakes", idx), hs_cnt, 3);
    chk($sformatf("t%0d_queue_empty", idx), exp_q.size(), 0);
    chk($sformatf("t%0d_sready_seen", idx), saw_sready, 1'b1);
    if (respond) begin
      exp_lat = 5 + (tv.stall ? 2 : 0) + (tv.poke ? 1 : 0);
      chk($sformatf("t%0d_latency", idx), lat, exp_lat);
    end
    s_axis_valid = 1'b0;
    check_results($sformatf("t%0d", idx), exp_c);
    tick();
    chk($sformatf("t%0d_done_pulse", idx), done, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    logic [8:0][15:0] zero_c, last_c;
    bit got;
    zero_c = '0;

    for (int i = 0; i < 9; i++) begin
      tvs[0].a[i] = 8'(i + 1);  tvs[0].b[i] = 8'(i + 1);
      tvs[1].a[i] = 8'(i + 1);  tvs[1].b[i] = 8'(i + 10);
      tvs[2].a[i] = 8'hff;      tvs[2].b[i] = 8'h00;
    end
    tvs[0].beats = {48'h090807090603, 48'h060504080502, 48'h030201070401};
    tvs[0].c     = {16'd150, 16'd126, 16'd102, 16'd96, 16'd81, 16'd66, 16'd42, 16'd36, 16'd30};
    tvs[0].stall = 0; tvs[0].poke = 0;
    tvs[1].beats = {48'h090807120f0c, 48'h060504110e0b, 48'h030201100d0a};
    tvs[1].c     = {16'hffff, 16'h8000, 16'h0001, 16'h1234, 16'habcd, 16'h0000, 16'h7fff, 16'h00ff, 16'hff00};
    tvs[1].stall = 1; tvs[1].poke = 0;
    tvs[2].beats = {48'hffffff000000, 48'hffffff000000, 48'hffffff000000};
    tvs[2].c     = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tvs[2].stall = 0; tvs[2].poke = 1;

    tick(); tick();
    chk("rst_valid", m_axis_valid, 1'b0);
    chk("rst_data", m_axis_data, 48'h0);
    chk("rst_sready", s_axis_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    check_results("rst", zero_c);
    axi_rst = 1'b0;
    tick();

    for (int t = 0; t < 3; t++) run_txn(t, 1'b1, 1'b1, 1'b0, tvs[t].c);

    // Start pulsed during SEND must not have queued a second transaction.
    got = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) got = 1;
    end
    chk("start_not_queued", got, 1'b0);
    run_txn(2, 1'b0, 1'b1, 1'b0, tvs[2].c);
    last_c = tvs[2].c;

`ifdef SYSTOLIC_HOST_TIMEOUT_EN
    run_txn(0, 1'b1, 1'b0, 1'b1, last_c);
`endif

    // Reset while waiting for the result.
    for (int k = 0; k < 3; k++) exp_q.push_back(tvs[2].beats[k]);
    s_axis_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (s_axis_ready) got = 1;
    end
    chk("rst_wait_reached", got, 1'b1);
    tick();
    axi_rst = 1'b1;
    tick();
    axi_rst = 1'b0;
    chk("midrst_valid", m_axis_valid, 1'b0);
    chk("midrst_data", m_axis_data, 48'h0);
    chk("midrst_sready", s_axis_ready, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_err", err, 1'b0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) got = 1;
      tick();
    end
    chk("midrst_no_done", got, 1'b0);
    check_results("midrst", zero_c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
